// File: rtl/nstack_pkg.sv
// Shared definitions for the stack decoder and the hardware LIFO behind it.
// Holds the write-back code that targets the stack, the opcodes and the default geometry.
package nstack_pkg;

  localparam logic [7:0] STACK_TOP_REG = 8'b0010_0000;

  localparam logic [7:0] OP_POP   = 8'h01;
  localparam logic [7:0] OP_PUSH  = 8'h02;
  localparam logic [7:0] OP_PUSHI = 8'h03;
  localparam logic [7:0] OP_GSA   = 8'h04;

  localparam int unsigned DEFAULT_DEPTH = 64;
  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_POP  = 2'b01,
    REQ_PUSH = 2'b10,
    REQ_SWAP = 2'b11
  } stack_req_e;

endpackage

// File: rtl/nstack_mem.sv
// Storage for every stack entry below the cached top.
// One synchronous write port, one asynchronous read port.
module nstack_mem
  import nstack_pkg::*;
#(
  parameter int unsigned ENTRIES = DEFAULT_DEPTH - 1,
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned AW      = 6
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [ENTRIES];

  // NOTE: the array has no reset; a slot is only read after a push has written it.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/nstack_unit.sv
// Hardware LIFO serving the stack decoder: registered top-of-stack, DEPTH-1 entry
// array beneath it, registered count/full/empty and sticky overflow/underflow flags.
module nstack_unit
  import nstack_pkg::*;
#(
  parameter int unsigned DEPTH         = DEFAULT_DEPTH,
  parameter int unsigned WIDTH         = DEFAULT_WIDTH,
  parameter logic [7:0]  STACK_TOP_REG = nstack_pkg::STACK_TOP_REG
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             STACK_pop_flag,
  input  logic             STACK_write_back_flag,
  input  logic [7:0]       STACK_write_back_code,
  input  logic [WIDTH-1:0] STACK_write_back_value,
  input  logic             err_clear,
  output logic [WIDTH-1:0] STACK_TOP,
  output logic [15:0]      STACK_AMOUNT,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH - 1 > 1) ? $clog2(DEPTH - 1) : 1;

  if (DEPTH < 2 || DEPTH > 65535) begin : g_bad_depth
    $fatal(1, "nstack_unit: DEPTH must be in 2..65535");
  end

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             push, pop;
  stack_req_e       req;
  logic             mem_wr_en;
  logic [AW-1:0]    mem_wr_addr, mem_rd_addr;
  logic [WIDTH-1:0] mem_rd_data;

  assign push = STACK_write_back_flag && (STACK_write_back_code == STACK_TOP_REG);
  assign pop  = STACK_pop_flag;
  assign req  = stack_req_e'({push, pop});

  // Entry below the top sits at count-2; a spilled top goes to count-1.
  assign mem_wr_addr = AW'(count_q - CW'(1));
  assign mem_rd_addr = AW'(count_q - CW'(2));

  nstack_mem #(
    .ENTRIES (DEPTH - 1),
    .WIDTH   (WIDTH),
    .AW      (AW)
  ) u_mem (
    .clock   (clock),
    .wr_en   (mem_wr_en),
    .wr_addr (mem_wr_addr),
    .wr_data (tos_q),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_rd_data)
  );

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    count_d   = count_q;
    tos_d     = tos_q;
    mem_wr_en = 1'b0;
    ovf_d     = ovf_q && !err_clear;
    unf_d     = unf_q && !err_clear;

    unique case (req)
      REQ_PUSH: begin
        if (count_q == CW'(DEPTH)) begin
          ovf_d = 1'b1;
        end else begin
          mem_wr_en = (count_q != '0);
          tos_d     = STACK_write_back_value;
          count_d   = count_q + CW'(1);
        end
      end
      REQ_POP: begin
        if (count_q == '0) begin
          unf_d = 1'b1;
        end else if (count_q == CW'(1)) begin
          tos_d   = '0;
          count_d = '0;
        end else begin
          tos_d   = mem_rd_data;
          count_d = count_q - CW'(1);
        end
      end
      REQ_SWAP: begin
        tos_d = STACK_write_back_value;
        if (count_q == '0) begin
          count_d = CW'(1);
          unf_d   = 1'b1;
        end
      end
      default: ;
    endcase

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tos_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tos_q   <= tos_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign STACK_TOP     = tos_q;
  assign STACK_AMOUNT  = 16'(count_q);
  assign stack_full    = full_q;
  assign stack_empty   = empty_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_nstack_unit.sv
// Randomized and directed bench for nstack_unit (DEPTH=4) against a queue-based
// LIFO model; outputs are sampled on the falling edge.
module tb_nstack_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             pop_flag;
  logic             wb_flag;
  logic [7:0]       wb_code;
  logic [WIDTH-1:0] wb_value;
  logic             err_clear;
  logic [WIDTH-1:0] stack_top;
  logic [15:0]      stack_amount;
  logic             stack_full, stack_empty, overflow_err, underflow_err;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] model_q[$];
  logic             model_ovf;
  logic             model_unf;

  nstack_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH), .STACK_TOP_REG(8'h20)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .STACK_pop_flag         (pop_flag),
    .STACK_write_back_flag  (wb_flag),
    .STACK_write_back_code  (wb_code),
    .STACK_write_back_value (wb_value),
    .err_clear              (err_clear),
    .STACK_TOP              (stack_top),
    .STACK_AMOUNT           (stack_amount),
    .stack_full             (stack_full),
    .stack_empty            (stack_empty),
    .overflow_err           (overflow_err),
    .underflow_err          (underflow_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = model_q.size();
    check({tag, ".top"},   stack_top, (n == 0) ? 32'h0 : model_q[n-1]);
    check({tag, ".amount"}, 32'(stack_amount), 32'(n));
    check({tag, ".full"},  32'(stack_full), 32'(n == DEPTH));
    check({tag, ".empty"}, 32'(stack_empty), 32'(n == 0));
    check({tag, ".ovf"},   32'(overflow_err), 32'(model_ovf));
    check({tag, ".unf"},   32'(underflow_err), 32'(model_unf));
  endtask

  // Reference behaviour written directly from the LIFO rules.
  task automatic model_update(input logic w, input logic [7:0] c, input logic [WIDTH-1:0] v,
                              input logic p, input logic clr);
    logic is_push, set_o, set_u;
    is_push = w && (c == 8'h20);
    set_o = 1'b0;
    set_u = 1'b0;
    if (is_push && p) begin
      if (model_q.size() == 0) begin
        model_q.push_back(v);
        set_u = 1'b1;
      end else begin
        model_q[model_q.size()-1] = v;
      end
    end else if (is_push) begin
      if (model_q.size() == DEPTH) set_o = 1'b1;
      else model_q.push_back(v);
    end else if (p) begin
      if (model_q.size() == 0) set_u = 1'b1;
      else void'(model_q.pop_back());
    end
    model_ovf = set_o ? 1'b1 : (clr ? 1'b0 : model_ovf);
    model_unf = set_u ? 1'b1 : (clr ? 1'b0 : model_unf);
  endtask

  // Called just after a falling edge: drive, clock once, sample on the next falling edge.
  task automatic step(input string tag, input logic w, input logic [7:0] c,
                      input logic [WIDTH-1:0] v, input logic p, input logic clr);
    wb_flag   = w;
    wb_code   = c;
    wb_value  = v;
    pop_flag  = p;
    err_clear = clr;
    @(posedge clock);
    model_update(w, c, v, p, clr);
    @(negedge clock);
    wb_flag   = 1'b0;
    pop_flag  = 1'b0;
    err_clear = 1'b0;
    check_all(tag);
  endtask

  task automatic do_push(input string tag, input logic [WIDTH-1:0] v);
    step(tag, 1'b1, 8'h20, v, 1'b0, 1'b0);
  endtask

  task automatic do_pop(input string tag);
    step(tag, 1'b0, 8'h00, '0, 1'b1, 1'b0);
  endtask

  initial begin
    model_ovf = 1'b0;
    model_unf = 1'b0;
    reset     = 1'b1;
    pop_flag  = 1'b0;
    wb_flag   = 1'b0;
    wb_code   = 8'h00;
    wb_value  = '0;
    err_clear = 1'b0;
    #1;
    check_all("reset");
    @(negedge clock);
    reset = 1'b0;

    // Asynchronous reset in the middle of a cycle.
    do_push("pre_rst0", 32'hA1);
    do_push("pre_rst1", 32'hA2);
    do_push("pre_rst2", 32'hA3);
    #2 reset = 1'b1;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
    check_all("async_rst");
    @(negedge clock);
    reset = 1'b0;

    do_push("push11", 32'h11);
    do_push("push22", 32'h22);
    do_push("push33", 32'h33);
    check("seq.top33", stack_top, 32'h33);
    do_pop("pop_a");
    check("seq.top22", stack_top, 32'h22);
    do_pop("pop_b");
    do_pop("pop_c");
    check("seq.empty_top", stack_top, 32'h0);

    step("other_code", 1'b1, 8'h05, 32'hAA, 1'b0, 1'b0);

    for (int i = 1; i <= 5; i++) do_push("fill", 32'(i * 16 + i));
    check("ovf.top4", stack_top, 32'h44);
    check("ovf.flag", 32'(overflow_err), 32'h1);
    step("clr_ovf", 1'b0, 8'h00, '0, 1'b0, 1'b1);
    step("swap_full", 1'b1, 8'h20, 32'hBEEF, 1'b1, 1'b0);
    step("ovf_vs_clr", 1'b1, 8'h20, 32'h5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) do_pop("drain");

    do_pop("pop_empty");
    step("swap_empty", 1'b1, 8'h20, 32'h77, 1'b1, 1'b0);
    check("swap_empty.top", stack_top, 32'h77);
    do_push("push55", 32'h55);
    step("swap_cnt2", 1'b1, 8'h20, 32'h99, 1'b1, 1'b0);
    check("swap_cnt2.top", stack_top, 32'h99);
    do_pop("pop_after_swap");
    check("below_kept", stack_top, 32'h77);
    step("clr_unf", 1'b0, 8'h00, '0, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic       w, p, clr;
      logic [7:0] c;
      w   = ($urandom_range(0, 99) < 55);
      c   = ($urandom_range(0, 9) < 8) ? 8'h20 : 8'($urandom);
      p   = ($urandom_range(0, 99) < 40);
      clr = ($urandom_range(0, 99) < 10);
      step("rand", w, c, $urandom, p, clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
